// File: rtl/axi4s_rr_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_INPUTS AXI4-Stream sources onto one sink,
// holding each grant from the first beat through the tlast beat.
module axi4s_rr_arbiter #(
    parameter int AXI_WIDTH  = 64,
    parameter int NUM_INPUTS = 4,
    parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_INPUTS*AXI_WIDTH-1:0]   m_tdata_i,
    input  logic [NUM_INPUTS-1:0]             m_tvalid_i,
    output logic [NUM_INPUTS-1:0]             m_tready_o,
    input  logic [NUM_INPUTS-1:0]             m_tlast_i,
    input  logic [NUM_INPUTS*AXI_WIDTH/8-1:0] m_tkeep_i,
    output logic [AXI_WIDTH-1:0]              s_tdata_o,
    output logic                              s_tvalid_o,
    input  logic                              s_tready_i,
    output logic                              s_tlast_o,
    output logic [AXI_WIDTH/8-1:0]            s_tkeep_o,
    output logic [ID_WIDTH-1:0]               s_tid_o,
    output logic                              dbg_state_o,
    output logic [ID_WIDTH-1:0]               dbg_prio_o
);

    localparam int          KEEP_WIDTH = AXI_WIDTH / 8;
    localparam int unsigned NUM_U      = NUM_INPUTS;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [ID_WIDTH-1:0]   grant_r;
    logic [ID_WIDTH-1:0]   grant_d;
    logic [ID_WIDTH-1:0]   prio_r;
    logic [ID_WIDTH-1:0]   prio_d;

    logic [AXI_WIDTH-1:0]  tdata_arr [NUM_INPUTS];
    logic [KEEP_WIDTH-1:0] tkeep_arr [NUM_INPUTS];

    logic                  sel_found;
    logic [ID_WIDTH-1:0]   sel_idx;
    logic [ID_WIDTH-1:0]   cand;

    // Index arithmetic modulo NUM_INPUTS; base < NUM_INPUTS and off < NUM_INPUTS,
    // so a single conditional subtract is enough.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_U) begin
            sum = sum - NUM_U;
        end
        return ID_WIDTH'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            tdata_arr[i] = m_tdata_i[i*AXI_WIDTH +: AXI_WIDTH];
            tkeep_arr[i] = m_tkeep_i[i*KEEP_WIDTH +: KEEP_WIDTH];
        end
    end

    // First requesting input searching upward from prio_r, wrapping at NUM_INPUTS.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = prio_r;
        cand      = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = wrap_add(prio_r, k);
            if (!sel_found && m_tvalid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Handshakes: a beat moves on a rising edge where valid and ready are both high.
    // Valid never depends on ready; the granted input's ready is s_tready_i passed through.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_r;
        prio_d     = prio_r;
        s_tvalid_o = 1'b0;
        m_tready_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                s_tvalid_o          = m_tvalid_i[grant_r];
                m_tready_o[grant_r] = s_tready_i;
                if (m_tvalid_i[grant_r] && s_tready_i && m_tlast_i[grant_r]) begin
                    state_d = ST_IDLE;
                    prio_d  = wrap_add(grant_r, 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_r <= '0;
            prio_r  <= '0;
        end else begin
            state_q <= state_d;
            grant_r <= grant_d;
            prio_r  <= prio_d;
        end
    end

    assign s_tdata_o   = tdata_arr[grant_r];
    assign s_tkeep_o   = tkeep_arr[grant_r];
    assign s_tlast_o   = m_tlast_i[grant_r];
    assign s_tid_o     = grant_r;
    assign dbg_state_o = (state_q == ST_LOCKED);
    assign dbg_prio_o  = prio_r;

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// Randomized bench for axi4s_rr_arbiter: per-source packet drivers feed expected beats into
// per-source queues; a negedge monitor checks outputs against a round-robin reference model.
module tb_axi4s_rr_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int KW = W / 8;
    localparam int IW = $clog2(N);
    localparam int EW = W + KW + 1;

    logic              clk;
    logic              rst_i;
    logic [N*W-1:0]    m_tdata_i;
    logic [N-1:0]      m_tvalid_i;
    logic [N-1:0]      m_tready_o;
    logic [N-1:0]      m_tlast_i;
    logic [N*KW-1:0]   m_tkeep_i;
    logic [W-1:0]      s_tdata_o;
    logic              s_tvalid_o;
    logic              s_tready_i;
    logic              s_tlast_o;
    logic [KW-1:0]     s_tkeep_o;
    logic [IW-1:0]     s_tid_o;
    logic              dbg_state_o;
    logic [IW-1:0]     dbg_prio_o;

    axi4s_rr_arbiter #(.AXI_WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_tdata_i(m_tdata_i), .m_tvalid_i(m_tvalid_i), .m_tready_o(m_tready_o),
        .m_tlast_i(m_tlast_i), .m_tkeep_i(m_tkeep_i),
        .s_tdata_o(s_tdata_o), .s_tvalid_o(s_tvalid_o), .s_tready_i(s_tready_i),
        .s_tlast_o(s_tlast_o), .s_tkeep_o(s_tkeep_o), .s_tid_o(s_tid_o),
        .dbg_state_o(dbg_state_o), .dbg_prio_o(dbg_prio_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- source driver state ----------------
    logic [W-1:0]  src_data  [N];
    logic [KW-1:0] src_keep  [N];
    logic          src_last  [N];
    logic          presenting[N];
    int            beat_idx  [N];
    int            cur_len   [N];
    int            pkts_left [N];
    int            len_lo    [N];
    int            len_hi    [N];
    int            stall_at  [N];
    int            stall_len [N];
    int            stall_cnt [N];
    int            gap_pct;
    int            ready_pct;
    bit            pattern_data;
    bit            chk_gap;
    int            timeouts_req;

    always_comb begin
        m_tdata_i  = '0;
        m_tkeep_i  = '0;
        m_tvalid_i = '0;
        m_tlast_i  = '0;
        for (int i = 0; i < N; i++) begin
            m_tdata_i[i*W +: W]   = src_data[i];
            m_tkeep_i[i*KW +: KW] = src_keep[i];
            m_tvalid_i[i]         = presenting[i];
            m_tlast_i[i]          = src_last[i];
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0] exp_q [N][$];
    int            exp_grant_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            hs_total = 0;
    int            mon_cyc = 0;
    int            timeouts_seen = 0;
    bit            mdl_free = 1'b1;
    int            mdl_prio = 0;
    int            mdl_grant = 0;
    bit            first_beat = 1'b0;
    bit            just_reset = 1'b0;
    bit            gap_armed = 1'b0;
    int            last_start = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, mon_cyc);
        end
    endtask

    // Round-robin rule: first requesting index scanning prio, prio+1, ... modulo N.
    function automatic int rr_pick(input logic [N-1:0] v, input int prio);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (prio + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0]  exp_rdy;
        logic [EW-1:0] exp_beat;
        mon_cyc++;
        if (timeouts_req > timeouts_seen) begin
            timeouts_seen++;
            n_vec++;
            n_err++;
        end
        if (rst_i) begin
            mdl_free   = 1'b1;
            mdl_prio   = 0;
            mdl_grant  = 0;
            first_beat = 1'b0;
            just_reset = 1'b1;
            gap_armed  = 1'b0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            if (just_reset) begin
                chk("reset_tid", 128'(s_tid_o), 128'(0));
                just_reset = 1'b0;
            end
            chk("state_locked", 128'(dbg_state_o), 128'(!mdl_free));
            chk("prio", 128'(dbg_prio_o), 128'(mdl_prio));
            if (mdl_free) begin
                chk("idle_tvalid", 128'(s_tvalid_o), 128'(0));
                chk("idle_tready", 128'(m_tready_o), 128'(0));
                if (|m_tvalid_i) begin
                    mdl_grant  = rr_pick(m_tvalid_i, mdl_prio);
                    mdl_free   = 1'b0;
                    first_beat = 1'b1;
                end
            end else begin
                exp_rdy            = '0;
                exp_rdy[mdl_grant] = s_tready_i;
                chk("locked_tid", 128'(s_tid_o), 128'(mdl_grant));
                chk("locked_tvalid", 128'(s_tvalid_o), 128'(m_tvalid_i[mdl_grant]));
                chk("locked_tready", 128'(m_tready_o), 128'(exp_rdy));
                if (m_tvalid_i[mdl_grant] && s_tready_i) begin
                    hs_total++;
                    if (exp_q[mdl_grant].size() == 0) begin
                        chk("beat_expected", 128'(0), 128'(1));
                    end else begin
                        exp_beat = exp_q[mdl_grant].pop_front();
                        chk("beat", 128'({s_tlast_o, s_tkeep_o, s_tdata_o}), 128'(exp_beat));
                        if (first_beat) begin
                            first_beat = 1'b0;
                            if (exp_grant_q.size() > 0)
                                chk("grant_order", 128'(s_tid_o), 128'(exp_grant_q.pop_front()));
                            if (chk_gap && gap_armed)
                                chk("pkt_spacing", 128'(mon_cyc - last_start), 128'(2));
                            gap_armed  = chk_gap;
                            last_start = mon_cyc;
                        end
                        if (exp_beat[EW-1]) begin
                            mdl_free = 1'b1;
                            mdl_prio = (mdl_grant + 1) % N;
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = m_tvalid_i & m_tready_o;
        @(posedge clk);
        #1;
        s_tready_i = ($urandom_range(99) < ready_pct);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                presenting[i] = 1'b0;
                if (src_last[i]) begin
                    beat_idx[i] = 0;
                    pkts_left[i]--;
                end else begin
                    beat_idx[i]++;
                end
            end
            if (!presenting[i] && pkts_left[i] > 0) begin
                if (beat_idx[i] == stall_at[i] && stall_cnt[i] < stall_len[i]) begin
                    stall_cnt[i]++;
                end else if ($urandom_range(99) >= gap_pct) begin
                    if (beat_idx[i] == 0) cur_len[i] = $urandom_range(len_hi[i], len_lo[i]);
                    src_data[i]   = pattern_data ? W'(64'hA0 + beat_idx[i]) : {$urandom, $urandom};
                    src_keep[i]   = KW'($urandom);
                    src_last[i]   = (beat_idx[i] == cur_len[i] - 1);
                    presenting[i] = 1'b1;
                    exp_q[i].push_back({src_last[i], src_keep[i], src_data[i]});
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        s_tready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            presenting[i] = 1'b0;
            src_last[i]   = 1'b0;
            beat_idx[i]   = 0;
            pkts_left[i]  = 0;
            stall_at[i]   = -1;
            stall_len[i]  = 0;
            stall_cnt[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic set_src(input int i, input int npk, input int lo, input int hi);
        pkts_left[i] = npk;
        len_lo[i]    = lo;
        len_hi[i]    = hi;
    endtask

    function automatic bit all_done();
        bit d;
        d = mdl_free;
        for (int i = 0; i < N; i++)
            if (pkts_left[i] != 0 || presenting[i] || exp_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_until_idle(input int budget);
        int c;
        c = 0;
        while (!all_done() && c < budget) begin
            drive_cycle();
            c++;
        end
        if (!all_done()) begin
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
            timeouts_req++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int c;
        rst_i        = 1'b1;
        s_tready_i   = 1'b0;
        gap_pct      = 0;
        ready_pct    = 100;
        pattern_data = 1'b0;
        chk_gap      = 1'b0;
        timeouts_req = 0;
        for (int i = 0; i < N; i++) begin
            src_data[i] = '0; src_keep[i] = '0; src_last[i] = 1'b0; presenting[i] = 1'b0;
            beat_idx[i] = 0; cur_len[i] = 1; pkts_left[i] = 0; len_lo[i] = 1; len_hi[i] = 1;
            stall_at[i] = -1; stall_len[i] = 0; stall_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single 3-beat packet from input 2, pattern data 0xA0..0xA2.
        pattern_data = 1'b1;
        set_src(2, 1, 3, 3);
        exp_grant_q.push_back(2);
        run_until_idle(200);
        repeat (2) drive_cycle();
        pattern_data = 1'b0;

        // All inputs, back-to-back 2-beat packets: strict rotation 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 2, 2, 2);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) exp_grant_q.push_back(i);
        run_until_idle(400);

        // Inputs 0 and 1 with toggling downstream ready and source gaps.
        do_reset();
        ready_pct = 50;
        gap_pct   = 30;
        set_src(0, 6, 1, 5);
        set_src(1, 6, 1, 5);
        run_until_idle(1500);

        // Input 3 stalls 5 cycles mid-packet while 0 and 1 wait; priority wraps 3->0.
        do_reset();
        ready_pct = 100;
        gap_pct   = 0;
        set_src(3, 1, 3, 3);
        stall_at[3]  = 1;
        stall_len[3] = 5;
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        drive_cycle();
        set_src(0, 1, 2, 2);
        set_src(1, 1, 2, 2);
        run_until_idle(300);

        // Reset during beat 2 of a 4-beat packet, then arbitration restarts from input 0.
        do_reset();
        set_src(1, 1, 4, 4);
        exp_grant_q.push_back(1);
        base = hs_total;
        c    = 0;
        while (hs_total < base + 1 && c < 100) begin
            drive_cycle();
            c++;
        end
        if (hs_total < base + 1) begin
            $display("FAIL first_beat_timeout: no handshake after %0d cycles, expected one", c);
            timeouts_req++;
        end
        do_reset();
        set_src(1, 1, 2, 2);
        set_src(3, 1, 2, 2);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(3);
        run_until_idle(300);

        // Single-beat packets from input 1 only: one packet every 2 cycles.
        do_reset();
        chk_gap = 1'b1;
        set_src(1, 5, 1, 1);
        for (int k = 0; k < 5; k++) exp_grant_q.push_back(1);
        run_until_idle(300);
        drive_cycle();
        chk_gap = 1'b0;

        // Long random mix on all inputs.
        do_reset();
        ready_pct = 70;
        gap_pct   = 25;
        for (int i = 0; i < N; i++) set_src(i, 20, 1, 6);
        run_until_idle(6000);

        repeat (3) drive_cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
